u_rec: RTL and testbench

//  UART receive deframer, the receive-side partner of the 16x-oversampled transmitter.

---
 rtl/u_rec_pkg.sv | 25 ++
 rtl/u_rec_if.sv | 32 +++
 rtl/u_rec_sync.sv | 32 +++
 rtl/u_rec.sv | 158 +++++++++++++++
 tb/tb_u_rec.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/u_rec_pkg.sv
// Shared definitions for the UART receive deframer: state encodings, line levels,
// bit-cell timing constants and the word alignment helper.
package u_rec_pkg;

    localparam int DEF_WORD_LEN = 8;
    localparam int OVS          = 16;
    localparam int MID          = 7;

    localparam logic LO = 1'b0;
    localparam logic HI = 1'b1;

    typedef enum logic [2:0] {
        R_IDLE  = 3'd0,
        R_START = 3'd1,
        R_DATA  = 3'd2,
        R_STOP  = 3'd3,
        R_BREAK = 3'd4
    } rec_state_t;

    // Data enters at the top of the shift register, so short words sit in the upper bits.
    function automatic logic [7:0] align_word(input logic [7:0] shift_word, input int word_len);
        return shift_word >> (8 - word_len);
    endfunction

endpackage

// File: rtl/u_rec_if.sv
// Host-side and line-side signal bundle of the UART receive deframer.
interface u_rec_if;

    logic       uart_recH;
    logic [7:0] rec_dataH;
    logic       rec_validH;
    logic       rec_ackH;
    logic       frame_errH;
    logic       overrun_errH;
    logic       rec_busyH;

    modport master (
        input  uart_recH,
        input  rec_ackH,
        output rec_dataH,
        output rec_validH,
        output frame_errH,
        output overrun_errH,
        output rec_busyH
    );

    modport slave (
        output uart_recH,
        output rec_ackH,
        input  rec_dataH,
        input  rec_validH,
        input  frame_errH,
        input  overrun_errH,
        input  rec_busyH
    );

endinterface

// File: rtl/u_rec_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus a falling-edge detector
// on the synchronized value. All flops reset to the idle (high) line level.
module u_rec_sync
    import u_rec_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic rx_s,
    output logic fall
);

    logic meta;
    logic sync;
    logic sync_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta   <= HI;
            sync   <= HI;
            sync_d <= HI;
        end else begin
            meta   <= line;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    assign rx_s = sync;
    assign fall = (sync_d == HI) && (sync == LO);

endmodule

// File: rtl/u_rec.sv
// UART receive deframer: validates the start bit, samples the data bits mid-cell LSB-first,
// checks the stop bit and hands the word to the host through a valid/ack handshake.
module u_rec
    import u_rec_pkg::*;
#(
    parameter int WORD_LEN = DEF_WORD_LEN
) (
    input  logic     sys_clk,
    input  logic     sys_rst,
    u_rec_if.master  bus
);

    rec_state_t state;
    rec_state_t state_next;

    logic [3:0] cell_cnt;
    logic [3:0] cell_next;
    logic [3:0] bit_cnt;
    logic [3:0] bit_next;
    logic [7:0] shift_reg;
    logic [7:0] shift_next;

    logic       rx_s;
    logic       fall;
    logic       cell_end;
    logic       byte_done;
    logic       stop_bad;

    logic [7:0] rec_data;
    logic       rec_valid;
    logic       frame_err;
    logic       overrun_err;

    u_rec_sync u_sync (
        .clk  (sys_clk),
        .rst  (sys_rst),
        .line (bus.uart_recH),
        .rx_s (rx_s),
        .fall (fall)
    );

    assign cell_end = (cell_cnt == 4'(OVS - 1));

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= R_IDLE;
            cell_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            state     <= state_next;
            cell_cnt  <= cell_next;
            bit_cnt   <= bit_next;
            shift_reg <= shift_next;
        end
    end

    // Leaving R_START after half a cell puts every later cell_end at the middle of a bit.
    always_comb begin
        state_next = state;
        cell_next  = cell_cnt;
        bit_next   = bit_cnt;
        shift_next = shift_reg;
        byte_done  = 1'b0;
        stop_bad   = 1'b0;

        case (state)
            R_IDLE: begin
                cell_next = '0;
                if (fall) begin
                    state_next = R_START;
                end
            end

            R_START: begin
                if (cell_cnt == 4'(MID)) begin
                    cell_next = '0;
                    bit_next  = '0;
                    if (rx_s == HI) begin
                        state_next = R_IDLE;
                    end else begin
                        state_next = R_DATA;
                    end
                end else begin
                    cell_next = cell_cnt + 4'd1;
                end
            end

            R_DATA: begin
                cell_next = cell_cnt + 4'd1;
                if (cell_end) begin
                    shift_next = {rx_s, shift_reg[7:1]};
                    bit_next   = bit_cnt + 4'd1;
                    if (bit_cnt == 4'(WORD_LEN - 1)) begin
                        state_next = R_STOP;
                    end
                end
            end

            R_STOP: begin
                cell_next = cell_cnt + 4'd1;
                if (cell_end) begin
                    if (rx_s == HI) begin
                        byte_done  = 1'b1;
                        state_next = R_IDLE;
                    end else begin
                        stop_bad   = 1'b1;
                        state_next = R_BREAK;
                    end
                end
            end

            R_BREAK: begin
                cell_next = '0;
                if (rx_s == HI) begin
                    state_next = R_IDLE;
                end
            end

            default: begin
                state_next = R_IDLE;
                cell_next  = '0;
                bit_next   = '0;
            end
        endcase
    end

    // A completing word always wins; an ack in that same cycle absorbs the old word instead of overrunning.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rec_data    <= '0;
            rec_valid   <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            if (byte_done) begin
                rec_data  <= align_word(shift_reg, WORD_LEN);
                rec_valid <= 1'b1;
                if (rec_valid && !bus.rec_ackH) begin
                    overrun_err <= 1'b1;
                end else if (rec_valid && bus.rec_ackH) begin
                    overrun_err <= 1'b0;
                end
            end else if (rec_valid && bus.rec_ackH) begin
                rec_valid   <= 1'b0;
                overrun_err <= 1'b0;
            end
        end
    end

    assign bus.rec_dataH    = rec_data;
    assign bus.rec_validH   = rec_valid;
    assign bus.frame_errH   = frame_err;
    assign bus.overrun_errH = overrun_err;
    assign bus.rec_busyH    = (state != R_IDLE);

endmodule

// File: tb/tb_u_rec.sv
// Directed bench for the UART receive deframer: serial frames at 16 cycles per bit,
// checked against hand-computed results.
module tb_u_rec;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;

    int tests_run = 0;
    int errors    = 0;
    int fe_count  = 0;
    int fe_base   = 0;

    u_rec_if bus ();

    u_rec #(.WORD_LEN(8)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    // Counts every cycle frame_errH is high, so a wide pulse shows up as a count above one.
    always @(negedge sys_clk) begin
        if (bus.frame_errH === 1'b1) begin
            fe_count++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // One full frame: start, eight data bits LSB-first, stop; returns 160 cycles later.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
        bus.uart_recH = 1'b0;
        idleCycles(16);
        for (int i = 0; i < 8; i++) begin
            bus.uart_recH = data[i];
            idleCycles(16);
        end
        bus.uart_recH = stop_bit;
        idleCycles(16);
    endtask

    task automatic ackPulse();
        bus.rec_ackH = 1'b1;
        idleCycles(1);
        bus.rec_ackH = 1'b0;
    endtask

    initial begin
        bus.uart_recH = 1'b1;
        bus.rec_ackH  = 1'b0;
        idleCycles(3);
        sys_rst = 1'b0;
        idleCycles(2);

        checkOutput("reset_data",    32'(bus.rec_dataH),    32'h0);
        checkOutput("reset_valid",   32'(bus.rec_validH),   32'h0);
        checkOutput("reset_ferr",    32'(bus.frame_errH),   32'h0);
        checkOutput("reset_overrun", 32'(bus.overrun_errH), 32'h0);
        checkOutput("reset_busy",    32'(bus.rec_busyH),    32'h0);

        // Good frame 0xA5
        fe_base = fe_count;
        applyStimulus(8'hA5, 1'b1);
        checkOutput("a5_data",    32'(bus.rec_dataH),    32'hA5);
        checkOutput("a5_valid",   32'(bus.rec_validH),   32'h1);
        checkOutput("a5_overrun", 32'(bus.overrun_errH), 32'h0);
        checkOutput("a5_busy",    32'(bus.rec_busyH),    32'h0);
        checkOutput("a5_no_ferr", 32'(fe_count - fe_base), 32'h0);
        ackPulse();
        checkOutput("a5_ack_valid", 32'(bus.rec_validH), 32'h0);
        checkOutput("a5_ack_data",  32'(bus.rec_dataH),  32'hA5);
        idleCycles(32);

        // Five-cycle glitch: start detected, then rejected at mid start bit
        fe_base = fe_count;
        bus.uart_recH = 1'b0;
        idleCycles(4);
        checkOutput("glitch_busy", 32'(bus.rec_busyH), 32'h1);
        idleCycles(1);
        bus.uart_recH = 1'b1;
        idleCycles(20);
        checkOutput("glitch_idle",    32'(bus.rec_busyH),  32'h0);
        checkOutput("glitch_valid",   32'(bus.rec_validH), 32'h0);
        checkOutput("glitch_no_ferr", 32'(fe_count - fe_base), 32'h0);
        checkOutput("glitch_overrun", 32'(bus.overrun_errH), 32'h0);

        // 0x3C with a low stop bit, line held low for 40 bit cells in total
        fe_base = fe_count;
        applyStimulus(8'h3C, 1'b0);
        idleCycles(39 * 16);
        checkOutput("break_ferr_once", 32'(fe_count - fe_base), 32'h1);
        checkOutput("break_busy",      32'(bus.rec_busyH),  32'h1);
        checkOutput("break_data",      32'(bus.rec_dataH),  32'hA5);
        checkOutput("break_valid",     32'(bus.rec_validH), 32'h0);
        bus.uart_recH = 1'b1;
        idleCycles(5);
        checkOutput("break_release",   32'(bus.rec_busyH),  32'h0);
        idleCycles(32);

        // 0x11 then 0x22 back-to-back without ack
        applyStimulus(8'h11, 1'b1);
        checkOutput("b2b_first_data",    32'(bus.rec_dataH),    32'h11);
        checkOutput("b2b_first_overrun", 32'(bus.overrun_errH), 32'h0);
        applyStimulus(8'h22, 1'b1);
        checkOutput("b2b_data",    32'(bus.rec_dataH),    32'h22);
        checkOutput("b2b_valid",   32'(bus.rec_validH),   32'h1);
        checkOutput("b2b_overrun", 32'(bus.overrun_errH), 32'h1);
        ackPulse();
        checkOutput("b2b_ack_valid",   32'(bus.rec_validH),   32'h0);
        checkOutput("b2b_ack_overrun", 32'(bus.overrun_errH), 32'h0);
        idleCycles(32);

        // 0x33 left pending, then ack lands on the byte-complete cycle of 0x55
        applyStimulus(8'h33, 1'b1);
        checkOutput("pend_valid", 32'(bus.rec_validH), 32'h1);
        fork
            applyStimulus(8'h55, 1'b1);
            begin
                repeat (154) @(posedge sys_clk);
                #1;
                ackPulse();
            end
        join
        checkOutput("coinc_data",    32'(bus.rec_dataH),    32'h55);
        checkOutput("coinc_valid",   32'(bus.rec_validH),   32'h1);
        checkOutput("coinc_overrun", 32'(bus.overrun_errH), 32'h0);
        idleCycles(32);

        // Reset during data bit 4 of 0xFF
        fork
            applyStimulus(8'hFF, 1'b1);
            begin
                repeat (88) @(posedge sys_clk);
                #1;
                sys_rst = 1'b1;
                idleCycles(1);
                sys_rst = 1'b0;
                checkOutput("rst_data",    32'(bus.rec_dataH),    32'h0);
                checkOutput("rst_valid",   32'(bus.rec_validH),   32'h0);
                checkOutput("rst_overrun", 32'(bus.overrun_errH), 32'h0);
                checkOutput("rst_ferr",    32'(bus.frame_errH),   32'h0);
                checkOutput("rst_busy",    32'(bus.rec_busyH),    32'h0);
            end
        join
        checkOutput("rst_after_valid", 32'(bus.rec_validH), 32'h0);
        checkOutput("rst_after_busy",  32'(bus.rec_busyH),  32'h0);
        idleCycles(32);

        applyStimulus(8'h81, 1'b1);
        checkOutput("post_rst_data",    32'(bus.rec_dataH),    32'h81);
        checkOutput("post_rst_valid",   32'(bus.rec_validH),   32'h1);
        checkOutput("post_rst_overrun", 32'(bus.overrun_errH), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, errors);
        $finish;
    end

endmodule
